// File: rtl/task2_pkg.sv
// Shared types and constants for the RC4 key-scheduling stage.
package task2_pkg;

  localparam int         KEY_LEN = 3;
  localparam logic [7:0] LAST_I  = 8'd255;

  typedef enum logic [3:0] {
    WAIT          = 4'd0,
    GO_TO_S       = 4'd1,
    GET_S         = 4'd2,
    GO_TO_ROM     = 4'd3,
    GET_NEW_J     = 4'd4,
    START_SWAP_J  = 4'd5,
    GET_ADDRESS_J = 4'd6,
    SWAP          = 4'd7,
    DONE_SWAP     = 4'd8,
    INCREMENT     = 4'd9,
    FINISHED      = 4'd10
  } state_t;

  // Key byte 0 lives in the most significant byte of the 24-bit key.
  function automatic logic [7:0] key_byte(input logic [23:0] key, input logic [1:0] idx);
    case (idx)
      2'd0:    key_byte = key[23:16];
      2'd1:    key_byte = key[15:8];
      default: key_byte = key[7:0];
    endcase
  endfunction

endpackage

// File: rtl/task2_fsm.sv
// RC4 key scheduling over a 256-byte S RAM with a synchronous read port.
// Outputs are registered from the next-state values so the RAM sees them during the state that names them.
module task2_fsm
  import task2_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] secret_key,
  input  logic [7:0]  q,
  output logic [4:0]  address_d,
  output logic [7:0]  data_d,
  output logic        wren_d,
  input  logic [7:0]  q_d,
  input  logic [7:0]  q_m,
  output logic [4:0]  address_m,
  input  logic        finished_task1,
  output logic        wren,
  output logic [7:0]  data,
  output logic [7:0]  address,
  output logic        done_task2
);

  state_t     state, state_n;
  logic [7:0] i, i_n;
  logic [7:0] j, j_n;
  logic [1:0] k, k_n;
  logic [7:0] si, si_n;
  logic [7:0] sj, sj_n;
  logic [7:0] kb, kb_n;
  logic [7:0] address_n, data_n;
  logic       wren_n, done_n;
  logic       unused_inputs;

  assign address_d     = 5'd0;
  assign data_d        = 8'd0;
  assign wren_d        = 1'b0;
  assign address_m     = 5'd0;
  assign unused_inputs = ^{q_d, q_m};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= WAIT;
      i          <= 8'd0;
      j          <= 8'd0;
      k          <= 2'd0;
      si         <= 8'd0;
      sj         <= 8'd0;
      kb         <= 8'd0;
      address    <= 8'd0;
      data       <= 8'd0;
      wren       <= 1'b0;
      done_task2 <= 1'b0;
    end else begin
      state      <= state_n;
      i          <= i_n;
      j          <= j_n;
      k          <= k_n;
      si         <= si_n;
      sj         <= sj_n;
      kb         <= kb_n;
      address    <= address_n;
      data       <= data_n;
      wren       <= wren_n;
      done_task2 <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    i_n     = i;
    j_n     = j;
    k_n     = k;
    si_n    = si;
    sj_n    = sj;
    kb_n    = kb;
    case (state)
      WAIT:          if (finished_task1) state_n = GO_TO_S;
      GO_TO_S:       state_n = GET_S;
      GET_S: begin
        si_n    = q;
        state_n = GO_TO_ROM;
      end
      GO_TO_ROM: begin
        kb_n    = key_byte(secret_key, k);
        state_n = GET_NEW_J;
      end
      GET_NEW_J: begin
        j_n     = j + si + kb;
        state_n = START_SWAP_J;
      end
      START_SWAP_J:  state_n = GET_ADDRESS_J;
      GET_ADDRESS_J: begin
        sj_n    = q;
        state_n = SWAP;
      end
      SWAP:          state_n = DONE_SWAP;
      DONE_SWAP:     state_n = INCREMENT;
      INCREMENT: begin
        if (i == LAST_I) begin
          state_n = FINISHED;
        end else begin
          i_n     = i + 8'd1;
          // k tracks i mod KEY_LEN without a divider.
          k_n     = (k == 2'(KEY_LEN - 1)) ? 2'd0 : k + 2'd1;
          state_n = GO_TO_S;
        end
      end
      FINISHED:      state_n = FINISHED;
      default:       state_n = WAIT;
    endcase

    address_n = 8'd0;
    data_n    = 8'd0;
    wren_n    = 1'b0;
    done_n    = 1'b0;
    case (state_n)
      GO_TO_S:      address_n = i_n;
      START_SWAP_J: address_n = j_n;
      SWAP: begin
        address_n = i_n;
        data_n    = sj_n;
        wren_n    = 1'b1;
      end
      // When i == j this second write repeats the address with si, which is the same value.
      DONE_SWAP: begin
        address_n = j_n;
        data_n    = si_n;
        wren_n    = 1'b1;
      end
      FINISHED:     done_n = 1'b1;
      default:      ;
    endcase
  end

endmodule

// File: tb/tb_task2_fsm.sv
// Self-checking bench for task2_fsm: synchronous S RAM model plus a software KSA reference.
module tb_task2_fsm;
  import task2_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] secret_key;
  logic [7:0]  q;
  logic [4:0]  address_d;
  logic [7:0]  data_d;
  logic        wren_d;
  logic [7:0]  q_d;
  logic [7:0]  q_m;
  logic [4:0]  address_m;
  logic        finished_task1;
  logic        wren;
  logic [7:0]  data;
  logic [7:0]  address;
  logic        done_task2;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [256];
  logic        init_mem = 1'b0;
  logic [7:0]  exp_s [256];
  logic [15:0] exp_q [$];
  logic [15:0] first_w [8];
  int          nwrites;

  always #5 clk = ~clk;

  task2_fsm dut (
    .clk(clk), .reset(reset), .secret_key(secret_key), .q(q),
    .address_d(address_d), .data_d(data_d), .wren_d(wren_d),
    .q_d(q_d), .q_m(q_m), .address_m(address_m),
    .finished_task1(finished_task1), .wren(wren), .data(data),
    .address(address), .done_task2(done_task2)
  );

  // Synchronous S RAM: write and read address sampled at the edge, q valid next cycle.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int a = 0; a < 256; a++) mem[a] <= 8'(a);
    end else if (wren) begin
      mem[address] <= data;
    end
    q <= mem[address];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference KSA from the current RAM contents; records every expected write in order.
  task automatic build_model(input logic [23:0] key);
    logic [7:0] s [256];
    logic [7:0] jj, t;
    for (int a = 0; a < 256; a++) s[a] = mem[a];
    jj = 8'd0;
    exp_q.delete();
    for (int ii = 0; ii < 256; ii++) begin
      jj = jj + s[ii] + 8'(key >> (16 - 8 * (ii % 3)));
      exp_q.push_back({8'(ii), s[jj]});
      exp_q.push_back({jj, s[ii]});
      t = s[ii];
      s[ii] = s[jj];
      s[jj] = t;
    end
    for (int a = 0; a < 256; a++) exp_s[a] = s[a];
  endtask

  task automatic monitor(input int stop_i, output int cycles);
    logic [15:0] w;
    cycles  = 0;
    nwrites = 0;
    while (cycles < 3000) begin
      @(negedge clk);
      cycles++;
      if (wren) begin
        w = {address, data};
        if (nwrites < 8) first_w[nwrites] = w;
        nwrites++;
        if (exp_q.size() == 0) check("write_count", 32'(nwrites), 32'd512);
        else check("write", 32'(w), 32'(exp_q.pop_front()));
      end
      if (stop_i >= 0 && dut.state == SWAP && dut.i == 8'(stop_i)) return;
      if (done_task2) return;
    end
    check("done_timeout", 32'(done_task2), 32'd1);
  endtask

  task automatic full_run(input logic [23:0] key, input logic init);
    int cyc;
    int bad;
    reset    = 1'b0;
    init_mem = init;
    @(negedge clk);
    @(negedge clk);
    init_mem = 1'b0;
    @(negedge clk);
    build_model(key);
    secret_key     = key;
    reset          = 1'b1;
    finished_task1 = 1'b1;
    monitor(-1, cyc);
    check("done_latency", 32'(cyc), 32'd2305);
    check("writes_left", 32'(exp_q.size()), 32'd0);
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (!done_task2 || wren) bad++;
    end
    check("done_hold", 32'(bad), 32'd0);
    for (int a = 0; a < 256; a++) check("final_s", 32'(mem[a]), 32'(exp_s[a]));
  endtask

  initial begin
    int cyc;
    reset          = 1'b0;
    finished_task1 = 1'b0;
    secret_key     = 24'h000249;
    q_d            = 8'h5A;
    q_m            = 8'hA5;

    // Reset and idle in WAIT.
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_state", 32'(dut.state), 32'(WAIT));
    check("idle_wren", 32'(wren), 32'd0);
    check("idle_done", 32'(done_task2), 32'd0);
    check("idle_address", 32'(address), 32'd0);
    check("tie_address_d", 32'(address_d), 32'd0);
    check("tie_data_d", 32'(data_d), 32'd0);
    check("tie_wren_d", 32'(wren_d), 32'd0);
    check("tie_address_m", 32'(address_m), 32'd0);

    // Known key from an identity S array, including the early j values.
    full_run(24'h000249, 1'b1);
    check("w0", 32'(first_w[0]), 32'h0000);
    check("w1", 32'(first_w[1]), 32'h0000);
    check("w2_i1", 32'(first_w[2]), 32'h0103);
    check("w3_j3", 32'(first_w[3]), 32'h0301);
    check("w4_i2", 32'(first_w[4]), 32'h024E);
    check("w5_j4e", 32'(first_w[5]), 32'h4E02);
    check("w6_i3", 32'(first_w[6]), 32'h034F);
    check("w7_j4f", 32'(first_w[7]), 32'h4F01);

    // Reset during SWAP at i=100, then restart from whatever S now holds.
    reset    = 1'b0;
    init_mem = 1'b1;
    @(negedge clk);
    @(negedge clk);
    init_mem = 1'b0;
    @(negedge clk);
    build_model(24'h000249);
    secret_key     = 24'h000249;
    reset          = 1'b1;
    finished_task1 = 1'b1;
    monitor(100, cyc);
    check("reached_i100", 32'(dut.i), 32'd100);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("mid_reset_state", 32'(dut.state), 32'(WAIT));
    check("mid_reset_i", 32'(dut.i), 32'd0);
    check("mid_reset_j", 32'(dut.j), 32'd0);
    check("mid_reset_wren", 32'(wren), 32'd0);
    check("mid_reset_done", 32'(done_task2), 32'd0);
    full_run(24'h000249, 1'b0);

    // Every add wraps with an all-ones key.
    full_run(24'hFFFFFF, 1'b1);

    // Random keys.
    repeat (3) full_run(24'($urandom), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/task2_fsm.md
Name: task2_fsm

Overview:
- Implements the RC4 key-scheduling algorithm (KSA) over a 256-byte S working memory.
- Starts once the S-init stage (task 1) reports completion; uses a 24-bit secret key.
- Signals done to the downstream decrypt stage (task 2b).
- The decrypted-RAM and message-ROM ports exist for interface compatibility and are tied off in this block.

Parameters:
- KEY_LEN, 3, key length in bytes; the key-index counter wraps at KEY_LEN-1.
- LAST_I, 255, final value of index i.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- secret_key  in  24  key; key[0]=bits[23:16], key[1]=[15:8], key[2]=[7:0].
- q  in  8  S RAM read data.
- address_d  out  5  decrypted RAM address; constant 0.
- data_d  out  8  decrypted RAM write data; constant 0.
- wren_d  out  1  decrypted RAM write enable; constant 0.
- q_d  in  8  decrypted RAM read data; unused.
- q_m  in  8  message ROM read data; unused.
- address_m  out  5  message ROM address; constant 0.
- finished_task1  in  1  level; high once S[k]=k init is complete.
- wren  out  1  S RAM write enable.
- data  out  8  S RAM write data.
- address  out  8  S RAM address.
- done_task2  out  1  high when KSA is complete.

Behaviour:
- One clock domain. reset low at a rising edge:
  - state=WAIT; i=0, j=0, k=0 (k = i mod 3), si=0, sj=0.
  - address=0, data=0, wren=0, done_task2=0.
- Reset applies in any state, including mid-operation.
- S RAM model: synchronous. Address/data/wren are sampled at a clock edge; q is valid in the following cycle.
- All outputs are registered (Moore).
- States and transitions:
  - WAIT: wren=0. If finished_task1=1 then GO_TO_S, else stay.
  - GO_TO_S: address=i, wren=0 -> GET_S.
  - GET_S: latch si<=q -> GO_TO_ROM.
  - GO_TO_ROM: select kb=key[k] -> GET_NEW_J.
  - GET_NEW_J: j<=(j+si+kb) mod 256, 8-bit wrap -> START_SWAP_J.
  - START_SWAP_J: address=j, wren=0 -> GET_ADDRESS_J.
  - GET_ADDRESS_J: latch sj<=q -> SWAP.
  - SWAP: address=i, data=sj, wren=1 -> DONE_SWAP.
  - DONE_SWAP: address=j, data=si, wren=1 -> INCREMENT.
  - INCREMENT: wren=0.
    - If i==LAST_I then FINISHED.
    - Otherwise i<=i+1, k<=(k==2)?0:k+1, then GO_TO_S.
  - FINISHED: done_task2=1, wren=0. Stays until reset.
- Iteration cost: 9 cycles; 256 iterations; done_task2 asserts about 2305 cycles after leaving WAIT.
- Case i==j: SWAP and DONE_SWAP both write the same address. The second write (si) wins; the value is unchanged, so this is correct.
- finished_task1 is sampled only in WAIT. A later deassertion has no effect.
- secret_key must be stable from WAIT exit until FINISHED.
- k is a modulo-3 counter; no divider.

Decomposition:
- Package task2_pkg: state enum (WAIT=0, GO_TO_S=1, GET_S=2, GO_TO_ROM=3, GET_NEW_J=4, START_SWAP_J=5, GET_ADDRESS_J=6, SWAP=7, DONE_SWAP=8, INCREMENT=9, FINISHED=10), KEY_LEN, LAST_I.
- Single module; no sub-module needed.

Test Plan:
- Reset/idle: reset=0 then 1, finished_task1=0 for 10 cycles -> state WAIT, wren=0, done_task2=0, address=0.
- Start + first iteration: key=0x000249, S[k]=k RAM model, finished_task1=1 -> GO_TO_S reads addr 0; j=0; writes S[0]=0 twice; next GO_TO_S drives address=1.
- j arithmetic, same key:
  - i=1: j=0+1+0x02=0x03; SWAP writes addr1<=3, DONE_SWAP writes addr3<=1.
  - i=2: j=0x03+2+0x49=0x4E.
  - i=3: key index wraps to key[0]=0x00, so j=0x4E+S[3].
- Wrap-around: key=0xFFFFFF -> j wraps mod 256 on every add; compare all 256 writes against a software KSA model.
- Completion: after the i=255 INCREMENT -> FINISHED, done_task2=1 held for 1000 cycles, wren=0; final S equals the reference KSA for 0x000249.
- Reset mid-run: assert reset at i=100 in SWAP -> next cycle state=WAIT, i=j=0, wren=0; with finished_task1 still high, KSA restarts from i=0.
